sram_arbiter: RTL and testbench

- Shares one SRAM-like bus between the fetch-side instruction requester and the memory-side data requester (loads/stores feeding data_sram_rdata into the memory stage).
- Grants one request per accept, locks the grant until the address is accepted, and tracks outstanding transactions in order so each data_ok/rdata returns to its issuer.
- Sits between the pipeline front/back ends and the bus bridge.

---
 rtl/sram_arbiter_pkg.sv | 19 +
 rtl/sram_arb_order_fifo.sv | 54 +++++
 rtl/sram_arbiter.sv | 146 ++++++++++++++
 tb/tb_sram_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arbiter_pkg.sv
// Shared ids and encodings for the SRAM bus arbiter slice.
package sram_arbiter_pkg;

  typedef enum logic {
    SRC_INST = 1'b0,
    SRC_DATA = 1'b1
  } src_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_I = 2'd1,
    LOCK_D = 2'd2
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/sram_arb_order_fifo.sv
// In-order record of which requester owns each outstanding bus transaction.
module sram_arb_order_fifo
  import sram_arbiter_pkg::*;
#(
  parameter int MAX_OUTST = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  src_e                           push_src,
  input  logic                           pop,
  output src_e                           head,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(MAX_OUTST):0]     count
);

  localparam int PW = $clog2(MAX_OUTST);
  localparam int CW = PW + 1;

  src_e          mem [MAX_OUTST];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(MAX_OUTST));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_src;
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-requester SRAM bus arbiter with grant locking and in-order response routing.
// Optional SRAM_ARB_RR_EN: round-robin priority in IDLE instead of fixed data-first.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int MAX_OUTST = 4,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [31:0]       inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [3:0]        data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [31:0]       data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [31:0]       data_rdata,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [3:0]        bus_wstrb,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [31:0]       bus_rdata
);

  localparam int CNT_W = $clog2(MAX_OUTST) + 1;

  state_e           state_q, state_d;
  src_e             win;
  logic             win_v;
  logic             space;
  logic             pop_v;
  logic             acc;
  logic             data_first;
  src_e             fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_cnt;

  // Responses and grants are held off while reset is asserted so outputs drop immediately.
  assign pop_v = bus_data_ok && !fifo_empty && !rst;
  assign space = !rst && (!fifo_full || pop_v);

`ifdef SRAM_ARB_RR_EN
  logic prio_d_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      prio_d_q <= 1'b1;
    else if (acc) prio_d_q <= (win == SRC_INST);
  end

  assign data_first = prio_d_q;
`else
  assign data_first = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    win_v     = 1'b0;
    win       = SRC_DATA;
    bus_wr    = 1'b0;
    bus_size  = SZ_WORD;
    bus_wstrb = '0;
    bus_addr  = '0;
    bus_wdata = '0;
    case (state_q)
      LOCK_I: begin
        win_v = 1'b1;
        win   = SRC_INST;
      end
      LOCK_D: begin
        win_v = 1'b1;
        win   = SRC_DATA;
      end
      default: begin
        if (space) begin
          if (data_req && (data_first || !inst_req)) begin
            win_v = 1'b1;
            win   = SRC_DATA;
          end else if (inst_req) begin
            win_v = 1'b1;
            win   = SRC_INST;
          end
        end
      end
    endcase
    bus_req = win_v && space;
    acc     = bus_req && bus_addr_ok;
    // A locked grant that is not presented (FIFO full) simply keeps its lock state.
    if (bus_req) begin
      if (acc)                  state_d = IDLE;
      else if (win == SRC_DATA) state_d = LOCK_D;
      else                      state_d = LOCK_I;
    end
    if (win_v && win == SRC_DATA) begin
      bus_wr    = data_wr;
      bus_size  = data_size;
      bus_wstrb = data_wstrb;
      bus_addr  = data_addr;
      bus_wdata = data_wdata;
    end else if (win_v) begin
      bus_addr  = inst_addr;
    end
  end

  assign inst_addr_ok = acc && (win == SRC_INST);
  assign data_addr_ok = acc && (win == SRC_DATA);
  assign inst_data_ok = pop_v && (fifo_head == SRC_INST);
  assign data_data_ok = pop_v && (fifo_head == SRC_DATA);
  assign inst_rdata   = bus_rdata;
  assign data_rdata   = bus_rdata;

  sram_arb_order_fifo #(
    .MAX_OUTST (MAX_OUTST)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (acc),
    .push_src (win),
    .pop      (pop_v),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_cnt)
  );

  always @(posedge clk) begin
    if (!rst) assert (fifo_cnt <= CNT_W'(MAX_OUTST));
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_sram_arbiter;
  import sram_arbiter_pkg::*;

  localparam int MAX_OUTST = 4;
  localparam int ADDR_W    = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [31:0]       inst_rdata;
  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [3:0]        data_wstrb;
  logic [ADDR_W-1:0] data_addr;
  logic [31:0]       data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [31:0]       data_rdata;
  logic              bus_req;
  logic              bus_wr;
  logic [1:0]        bus_size;
  logic [3:0]        bus_wstrb;
  logic [ADDR_W-1:0] bus_addr;
  logic [31:0]       bus_wdata;
  logic              bus_addr_ok;
  logic              bus_data_ok;
  logic [31:0]       bus_rdata;

  sram_arbiter #(
    .MAX_OUTST (MAX_OUTST),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_wstrb   (data_wstrb),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .bus_req      (bus_req),
    .bus_wr       (bus_wr),
    .bus_size     (bus_size),
    .bus_wstrb    (bus_wstrb),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_addr_ok  (bus_addr_ok),
    .bus_data_ok  (bus_data_ok),
    .bus_rdata    (bus_rdata)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: outstanding owners in accept order (0=I, 1=D), pending lock, RR priority.
  bit src_q[$];
  bit lock_v;
  bit lock_src;
  bit prio_d;
  bit last_iacc;
  bit last_dacc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    src_q.delete();
    lock_v   = 1'b0;
    lock_src = 1'b0;
    prio_d   = 1'b1;
  endtask

  task automatic idle_inputs();
    inst_req    = 1'b0;
    inst_addr   = '0;
    data_req    = 1'b0;
    data_wr     = 1'b0;
    data_size   = SZ_WORD;
    data_wstrb  = 4'h0;
    data_addr   = '0;
    data_wdata  = '0;
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    bus_rdata   = '0;
  endtask

  // Called at posedge+1; evaluates combinational outputs at posedge+4 against the model.
  task automatic settle();
    bit pop, space, w_v, w, req, acc, dfirst;
    #3;
    pop   = bus_data_ok && (src_q.size() > 0);
    space = (src_q.size() < MAX_OUTST) || pop;
    w_v   = 1'b0;
    w     = 1'b0;
`ifdef SRAM_ARB_RR_EN
    dfirst = prio_d;
`else
    dfirst = 1'b1;
`endif
    if (lock_v) begin
      w_v = 1'b1;
      w   = lock_src;
    end else if (space) begin
      if (data_req && (dfirst || !inst_req)) begin
        w_v = 1'b1;
        w   = 1'b1;
      end else if (inst_req) begin
        w_v = 1'b1;
        w   = 1'b0;
      end
    end
    req = w_v && space;
    acc = req && bus_addr_ok;
    check("bus_req", bus_req, req);
    check("inst_addr_ok", inst_addr_ok, acc && !w);
    check("data_addr_ok", data_addr_ok, acc && w);
    if (pop) begin
      check("inst_data_ok", inst_data_ok, !src_q[0]);
      check("data_data_ok", data_data_ok, src_q[0]);
      check("inst_rdata", inst_rdata, bus_rdata);
      check("data_rdata", data_rdata, bus_rdata);
    end else begin
      check("inst_data_ok_idle", inst_data_ok, 1'b0);
      check("data_data_ok_idle", data_data_ok, 1'b0);
    end
    if (req) begin
      check("bus_addr", bus_addr, w ? data_addr : inst_addr);
      check("bus_wr", bus_wr, w ? data_wr : 1'b0);
      check("bus_size", bus_size, w ? data_size : 2'd2);
      check("bus_wstrb", bus_wstrb, w ? data_wstrb : 4'h0);
      check("bus_wdata", bus_wdata, w ? data_wdata : 32'h0);
    end
    last_iacc = acc && !w;
    last_dacc = acc && w;
    if (pop) void'(src_q.pop_front());
    if (acc) begin
      src_q.push_back(w);
      lock_v = 1'b0;
      prio_d = !w;
    end else if (req) begin
      lock_v   = 1'b1;
      lock_src = w;
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  // Asserts rst asynchronously, checks outputs drop at once, releases after one edge.
  task automatic do_reset();
    rst = 1'b1;
    #2;
    check("rst_bus_req", bus_req, 1'b0);
    check("rst_addr_ok", {inst_addr_ok, data_addr_ok}, 2'b00);
    check("rst_data_ok", {inst_data_ok, data_data_ok}, 2'b00);
    check("rst_state", dut.state_q, IDLE);
    check("rst_count", dut.u_fifo.count, 0);
    idle_inputs();
    advance();
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    idle_inputs();
    model_reset();
    rst = 1'b1;
    do_reset();

    // Both request together: data first, instruction next, responses in accept order.
    inst_req = 1'b1; inst_addr = 32'h0000_0100;
    data_req = 1'b1; data_addr = 32'h0000_0200;
    bus_addr_ok = 1'b1;
    settle();
    check("t1_data_first", {inst_addr_ok, data_addr_ok}, 2'b01);
    advance();
    data_req = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h1111_1111;
    settle();
    check("t1_inst_second", inst_addr_ok, 1'b1);
    check("t1_resp1_data", {inst_data_ok, data_data_ok}, 2'b01);
    check("t1_resp1_rdata", data_rdata, 32'h1111_1111);
    advance();
    inst_req = 1'b0; bus_addr_ok = 1'b0; bus_rdata = 32'h2222_2222;
    settle();
    check("t1_resp2_inst", {inst_data_ok, data_data_ok}, 2'b10);
    check("t1_resp2_rdata", inst_rdata, 32'h2222_2222);
    advance();
    bus_data_ok = 1'b0;

    // Instruction grant stays locked while data request appears.
    do_reset();
    inst_req = 1'b1; inst_addr = 32'h0000_0A00;
    step();
    data_req = 1'b1; data_addr = 32'h0000_0B00; data_wr = 1'b1;
    data_wstrb = 4'hF; data_wdata = 32'hDEAD_BEEF;
    settle();
    check("t2_lock_addr1", bus_addr, 32'h0000_0A00);
    advance();
    settle();
    check("t2_lock_addr2", bus_addr, 32'h0000_0A00);
    advance();
    bus_addr_ok = 1'b1;
    settle();
    check("t2_inst_acc", {inst_addr_ok, data_addr_ok}, 2'b10);
    advance();
    inst_req = 1'b0;
    settle();
    check("t2_data_acc", data_addr_ok, 1'b1);
    check("t2_data_addr", bus_addr, 32'h0000_0B00);
    advance();
    data_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b1;
    repeat (2) step();
    bus_data_ok = 1'b0;

    // Fill to MAX_OUTST, then a pop lets the next request through in the same cycle.
    do_reset();
    data_req = 1'b1; data_wr = 1'b0; bus_addr_ok = 1'b1;
    for (int i = 0; i < MAX_OUTST; i++) begin
      data_addr = 32'h1000 + 32'(i * 4);
      settle();
      check("t3_fill_acc", data_addr_ok, 1'b1);
      advance();
    end
    data_addr = 32'h0000_1040;
    settle();
    check("t3_full_req", bus_req, 1'b0);
    check("t3_full_aok", data_addr_ok, 1'b0);
    check("t3_full_cnt", dut.u_fifo.count, MAX_OUTST);
    advance();
    bus_data_ok = 1'b1;
    settle();
    check("t3_pop_dok", data_data_ok, 1'b1);
    check("t3_pop_acc", data_addr_ok, 1'b1);
    advance();
    check("t3_cnt_held", dut.u_fifo.count, MAX_OUTST);
    data_req = 1'b0; bus_addr_ok = 1'b0;
    repeat (MAX_OUTST) step();
    bus_data_ok = 1'b0;

    // Stray response on empty FIFO, then async reset while locked on data.
    do_reset();
    bus_data_ok = 1'b1;
    settle();
    check("t5_stray", {inst_data_ok, data_data_ok}, 2'b00);
    advance();
    check("t5_stray_cnt", dut.u_fifo.count, 0);
    bus_data_ok = 1'b0; data_req = 1'b1; data_addr = 32'h0000_0080;
    step();
    check("t5_lock_d", dut.state_q, LOCK_D);
    do_reset();

    // Continuous contention: RR alternates D,I,...; fixed priority keeps serving D.
    inst_req = 1'b1; data_req = 1'b1; bus_addr_ok = 1'b1; bus_data_ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      inst_addr = $urandom & 32'hFFFF_FFFC;
      data_addr = $urandom;
      settle();
`ifdef SRAM_ARB_RR_EN
      check("prio_dacc", {inst_addr_ok, data_addr_ok}, (i % 2 == 0) ? 2'b01 : 2'b10);
`else
      check("prio_dacc", {inst_addr_ok, data_addr_ok}, 2'b01);
`endif
      advance();
    end
    inst_req = 1'b0; data_req = 1'b0; bus_addr_ok = 1'b0;
    repeat (MAX_OUTST) step();
    bus_data_ok = 1'b0;

    // Randomized traffic; requesters hold their request until accepted.
    do_reset();
    for (int c = 0; c < 800; c++) begin
      if (!inst_req && ($urandom % 3 == 0)) begin
        inst_req  = 1'b1;
        inst_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!data_req && ($urandom % 3 == 0)) begin
        data_req   = 1'b1;
        data_wr    = 1'($urandom);
        data_size  = 2'($urandom_range(0, 2));
        data_wstrb = 4'($urandom);
        data_addr  = $urandom;
        data_wdata = $urandom;
      end
      bus_addr_ok = ($urandom % 4) != 0;
      bus_data_ok = ($urandom % 3) != 0;
      bus_rdata   = $urandom;
      step();
      if (last_iacc) inst_req = 1'b0;
      if (last_dacc) data_req = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
